hc_sr04_echo_emulator: RTL
==========================

# hc_sr04_echo_emulator

Responder-side model of an HC-SR04 ultrasonic ranger: it accepts the trigger pulse an ultrasonic controller drives and returns an echo pulse whose high time encodes a programmed distance at 58 us per cm. It sits in place of the physical sensor, on the same board or in simulation, so that the distance-measurement path can be exercised with known, repeatable distances. It has its own 1 us timebase and fully defined timing from trigger to echo, echo width, timeout and hold-off.

## Interface
- CLK_FREQ_MHZ, 100, clock cycles per microsecond.
- TRIG_MIN_US, 10, minimum trigger high time accepted.
- BURST_DELAY_US, 200, time from trigger acceptance to echo rise (emulated 40 kHz burst).
- US_PER_CM, 58, echo microseconds per centimetre.
- MAX_CM, 400, largest reportable distance.
- TIMEOUT_US, 38000, echo width for no-object/out-of-range.
- HOLDOFF_US, 10000, dead time after echo fall; trigger ignored.
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- trig  in  1  trigger from controller; asynchronous to clk.
- dist_cm  in  16  programmed distance; sampled once per measurement.
- echo  out  1  echo pulse to controller.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse on the first cycle after echo falls.
- overrange  out  1  latched per measurement: 1 when echo is the timeout width.
- runt  out  1  one-cycle pulse when a trigger shorter than TRIG_MIN_US is rejected.

## Operation
- trig passes through a 2-flop synchronizer (trig_s). The FSM uses only trig_s and its registered previous value for edge detection.
- The FSM has five states: IDLE, TRIG, BURST, ECHO, HOLDOFF.
- IDLE: on a trig_s rising edge, go to TRIG. A trig_s that is already high (no edge) is ignored.
- TRIG: count the cycles trig_s is high. On the trig_s falling edge, if count >= TRIG_MIN_US*CLK_FREQ_MHZ, go to BURST. Otherwise pulse runt and go to IDLE.
- BURST: stay exactly BURST_DELAY_US*CLK_FREQ_MHZ cycles.
  - On the last cycle, latch the echo width W.
  - If dist_cm == 0 or dist_cm > MAX_CM, then W = TIMEOUT_US and overrange is set to 1. Otherwise W = dist_cm*US_PER_CM and overrange is set to 0.
  - Compute the product 22 bits wide; it cannot overflow because dist_cm is range-checked before use.
- ECHO: echo = 1 for exactly W*CLK_FREQ_MHZ cycles. Then go to HOLDOFF with echo = 0 and done = 1 for that first cycle.
- HOLDOFF: stay HOLDOFF_US*CLK_FREQ_MHZ cycles, then go to IDLE.
  - Trig edges during BURST, ECHO and HOLDOFF are ignored.
  - A trig held high across the HOLDOFF to IDLE transition does not start a measurement.
- Timebase: a prescaler counts 0..CLK_FREQ_MHZ-1 and produces a 1 us tick, plus a 17-bit microsecond counter.
  - Both restart at 0 on every state entry, so every duration is cycle-exact from state entry.
- overrange holds its value until the next BURST latch.
- dist_cm changes outside the BURST last cycle have no effect on the measurement in progress.

## Timing
- Reset values: echo = 0, busy = 0, done = 0, overrange = 0, runt = 0. State is IDLE, and all counters and synchronizer flops are 0.
- Reset asserted mid-operation drops echo immediately (asynchronously). After release the block is in IDLE and needs a fresh trig rising edge.
- Synchronizer latency: trig to trig_s is 2 edges. The edge is detected and the state changes on the next edge, giving 3 edges total.
- Trigger-fall to echo-rise latency: echo rises on rising edge 3 + BURST_DELAY_US*CLK_FREQ_MHZ, counted from the first edge that samples trig = 0 (20003 with defaults).
- Echo high time is exactly W*CLK_FREQ_MHZ cycles. done is high on the single cycle echo first reads 0.
- busy rises 3 edges after trig's first sampled 1. busy falls HOLDOFF_US*CLK_FREQ_MHZ cycles after done.
- runt asserts on the cycle the TRIG to IDLE transition takes effect.

## Test plan
- Defaults, dist_cm = 10, trig high 10 us:
  - echo rises 20003 edges after trig falls;
  - echo stays high 58000 cycles;
  - done pulses once;
  - overrange = 0.
- dist_cm = 0, then dist_cm = 401:
  - echo is high 3,800,000 cycles each time;
  - overrange = 1 each time;
  - the next run with dist_cm = 400 gives 2,320,000 cycles and overrange = 0.
- Trig high 9 us, then 10 us:
  - the first gives a runt pulse, busy returns to 0, and there is no echo;
  - the second produces a normal echo.
- Trig pulses during BURST, ECHO and HOLDOFF, and trig held high into IDLE:
  - no extra echo;
  - timing of the current measurement is unchanged.
- dist_cm changes from 10 to 20 mid-BURST and again mid-ECHO, with CLK_FREQ_MHZ = 4 and BURST_DELAY_US = 5:
  - the width reflects the value on the last BURST cycle only;
  - the mid-ECHO change has no effect.
- reset_n pulsed low mid-ECHO:
  - echo drops within the same cycle;
  - all outputs return to reset values;
  - the next valid trigger yields a normal measurement.

Source files
------------

// File: rtl/hc_sr04_echo_emulator.sv
// HC-SR04 responder: accepts a controller trigger and answers with an echo whose
// width encodes a programmed distance, with cycle-exact burst, echo and hold-off timing.
module hc_sr04_echo_emulator #(
  parameter int CLK_FREQ_MHZ   = 100,
  parameter int TRIG_MIN_US    = 10,
  parameter int BURST_DELAY_US = 200,
  parameter int US_PER_CM      = 58,
  parameter int MAX_CM         = 400,
  parameter int TIMEOUT_US     = 38000,
  parameter int HOLDOFF_US     = 10000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        trig,
  input  logic [15:0] dist_cm,
  output logic        echo,
  output logic        busy,
  output logic        done,
  output logic        overrange,
  output logic        runt
);

  localparam int PRE_W = (CLK_FREQ_MHZ > 1) ? $clog2(CLK_FREQ_MHZ) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(CLK_FREQ_MHZ - 1);
  localparam logic [16:0]      TRIG_LAST  = 17'(TRIG_MIN_US - 1);
  localparam logic [16:0]      BURST_LAST = 17'(BURST_DELAY_US - 1);
  localparam logic [16:0]      HOLD_LAST  = 17'(HOLDOFF_US - 1);

  typedef enum logic [2:0] {IDLE, TRIG, BURST, ECHO, HOLDOFF} state_t;

  state_t           state;
  logic             trig_m, trig_s, trig_d;
  logic [PRE_W-1:0] pre;
  logic [16:0]      us;
  logic [21:0]      width;

  logic tick, trig_rise, trig_fall, trig_long;
  logic burst_end, echo_end, hold_end;

  function automatic logic in_range(input logic [15:0] d);
    return (d != 16'd0) && (d <= 16'(MAX_CM));
  endfunction

  // Product is only formed for in-range distances, so 22 bits never overflow.
  function automatic logic [21:0] echo_width(input logic [15:0] d);
    if (!in_range(d)) return 22'(TIMEOUT_US);
    return 22'(d) * 22'(US_PER_CM);
  endfunction

  function automatic logic [16:0] sat_inc(input logic [16:0] v);
    return (v == 17'h1ffff) ? v : v + 17'd1;
  endfunction

  assign tick      = (pre == PRE_LAST);
  assign trig_rise = trig_s & ~trig_d;
  assign trig_fall = ~trig_s & trig_d;
  // Elapsed cycles since TRIG entry plus the entry cycle itself give the high time.
  assign trig_long = (us > TRIG_LAST) || (tick && (us == TRIG_LAST));
  assign burst_end = tick && (us == BURST_LAST);
  assign echo_end  = tick && ({5'b0, us} == width - 22'd1);
  assign hold_end  = tick && (us == HOLD_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      trig_m    <= 1'b0;
      trig_s    <= 1'b0;
      trig_d    <= 1'b0;
      pre       <= '0;
      us        <= '0;
      width     <= '0;
      echo      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overrange <= 1'b0;
      runt      <= 1'b0;
    end else begin
      trig_m <= trig;
      trig_s <= trig_m;
      trig_d <= trig_s;
      done   <= 1'b0;
      runt   <= 1'b0;

      if (tick) begin
        pre <= '0;
        us  <= sat_inc(us);
      end else begin
        pre <= pre + 1'b1;
      end

      // Every state entry below restarts the timebase so durations count from entry.
      case (state)
        IDLE: begin
          if (trig_rise) begin
            state <= TRIG;
            busy  <= 1'b1;
            pre   <= '0;
            us    <= '0;
          end
        end
        TRIG: begin
          if (trig_fall) begin
            pre <= '0;
            us  <= '0;
            if (trig_long) begin
              state <= BURST;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
              runt  <= 1'b1;
            end
          end
        end
        BURST: begin
          if (burst_end) begin
            state     <= ECHO;
            width     <= echo_width(dist_cm);
            overrange <= ~in_range(dist_cm);
            echo      <= 1'b1;
            pre       <= '0;
            us        <= '0;
          end
        end
        ECHO: begin
          if (echo_end) begin
            state <= HOLDOFF;
            echo  <= 1'b0;
            done  <= 1'b1;
            pre   <= '0;
            us    <= '0;
          end
        end
        HOLDOFF: begin
          if (hold_end) begin
            state <= IDLE;
            busy  <= 1'b0;
            pre   <= '0;
            us    <= '0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          echo  <= 1'b0;
        end
      endcase
    end
  end

endmodule
